expr_alu_rr_sched: RTL and testbench
====================================

# expr_alu_rr_sched

Round-robin scheduler that shares one registered expression ALU among `NREQ` requesters. It implements the same operator set as the expression datapath: add, sub, shifts, bitwise, xnor and compares. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one requester, latches its operands, computes the result, and holds it on a single response port with backpressure, tagged with the requester index.

## Interface
- `BITS`, 32, operand/result width (power of two, ≥ 8)
- `NREQ`, 4, number of requesters (2..8)
- `clock`  in  1  rising-edge clock, the only clock
- `reset_n`  in  1  synchronous reset, active-low; one clock, the only clock; reset is synchronous and active-low
- `req_valid`  in  NREQ  bit i: requester i has an operation pending
- `req_ready`  out  NREQ  bit i: requester i granted this cycle; at most one bit set
- `req_op`  in  4*NREQ  opcode of requester i at [4i+3:4i]
- `req_a`  in  BITS*NREQ  operand A of requester i at [BITS*i+BITS-1:BITS*i]
- `req_b`  in  BITS*NREQ  operand B of requester i, same packing
- `rsp_valid`  out  1  result held and valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  BITS  result
- `rsp_id`  out  3  index of the requester that issued the op
- `rsp_err`  out  1  opcode was illegal
- `ops_done`  out  16  count of completed responses, wraps at 16'hFFFF→0

## Operation
- Opcodes:
  - 0 ADD: a+b, mod 2^BITS
  - 1 SUB: a−b, mod 2^BITS
  - 2 SHL: a << b[log2(BITS)-1:0]
  - 3 SHR: logical a >> b[log2(BITS)-1:0]
  - 4 AND, 5 OR, 6 XOR
  - 7 XNOR: ~(a^b)
  - 8 LTU: unsigned a<b, zero-extended to BITS
  - 9 EQ: a==b, zero-extended
  - 10–15: illegal; result 0, `rsp_err`=1
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any `req_valid`, assert `req_ready` for the winner (combinational). At the clock edge, latch op/a/b/id and go to EXEC. If no `req_valid`, stay in IDLE.
  - EXEC: compute; register `rsp_data`/`rsp_err`/`rsp_id`; set `rsp_valid`; go to RESP. Unconditional; takes one cycle.
  - RESP: hold all `rsp_*` stable while `rsp_ready`=0. On an edge with `rsp_ready`=1: clear `rsp_valid`, increment `ops_done`, go to IDLE.
- Arbitration: round-robin pointer `ptr`, reset to 0.
  - Winner is the first `req_valid` bit at or above `ptr` (mod NREQ).
  - On each grant to i, `ptr` ← (i+1) mod NREQ.
  - No pointer update without a grant.
- `req_ready` is 0 in EXEC and RESP, so requests are never granted while a response is outstanding.
- Requester contract: hold valid, op, a and b stable until ready. The block does not check this.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `ops_done`=0, state IDLE, `ptr`=0.
- Reset mid-operation: any in-flight op is dropped with no response; the pointer returns to 0.
- Latency: grant at edge N → `rsp_valid`=1 after edge N+1.
- Throughput: best case one op per 3 cycles (IDLE, EXEC, RESP with `rsp_ready`=1).
- `req_ready` depends combinationally on `req_valid` and the state. `req_valid` does not affect `rsp_*` in the same cycle.
- All outputs except `req_ready` are registered.
- Simultaneous `rsp_ready`=1 and new `req_valid` in RESP: the response completes; the new grant occurs in the following IDLE cycle.
- `rsp_ready`=1 while `rsp_valid`=0: no effect.
- `ops_done` wraps from 65535 to 0 with no flag.

## Test plan
- **Basic ADD:** reset, then requester 0 sends ADD a=32'hFFFF_FFFF, b=2 with `rsp_ready`=1.
  - Required: `req_ready`[0] for one cycle; two edges later `rsp_data`=1, `rsp_id`=0, `rsp_err`=0; `ops_done`=1.
- **Round-robin:** all four requesters valid continuously, `rsp_ready`=1.
  - Required: `rsp_id` sequence 0,1,2,3,0; a grant every 3 cycles.
  - Then requesters 1 and 3 only, after the last grant to 0: grants 1,3,1.
- **Operator sweep:** requester 2, a=32'h0000_00F0, b=32'h0000_0003, opcodes 0–9.
  - Required results: F3, ED, 780, 1E, 0, F3, F3, FFFF_FF0C, 0, 0.
  - Opcode 12: `rsp_data`=0, `rsp_err`=1.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with requesters 1 and 2 valid.
  - Required: `rsp_*` stable; `req_ready`=0 throughout; `ops_done` unchanged until `rsp_ready`=1.
- **Reset mid-operation:** assert `reset_n`=0 in EXEC.
  - Required: `rsp_valid`=0 and all outputs at reset values after the edge; first grant after reset goes to the lowest valid index.
- **Counter wrap:** force 65536 completions.
  - Required: `ops_done` reads 65535, then 0.

Source files
------------

// File: rtl/expr_alu_rr_sched.sv
// Round-robin scheduler sharing one registered expression ALU among NREQ requesters.
// One op in flight: grant in IDLE, compute in EXEC, hold the response in RESP.
module expr_alu_rr_sched #(
  parameter int unsigned BITS = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [4*NREQ-1:0]      req_op,
  input  logic [BITS*NREQ-1:0]   req_a,
  input  logic [BITS*NREQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [BITS-1:0]        rsp_data,
  output logic [2:0]             rsp_id,
  output logic                   rsp_err,
  output logic [15:0]            ops_done
);
  localparam int unsigned SW = $clog2(BITS);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_LTU, OP_EQ
  } op_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [3:0]      op_q, op_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]      rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx, cand;
  logic [3:0]      op_sel;
  logic [BITS-1:0] a_sel, b_sel, alu_res;
  logic            alu_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      ops_done_q  <= ops_done_d;
    end
  end

  // First valid requester at or above ptr, scanning with wrap-around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        op_sel = req_op[4*i +: 4];
        a_sel  = req_a[BITS*i +: BITS];
        b_sel  = req_b[BITS*i +: BITS];
      end
    end
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_SHL:  alu_res = a_q << b_q[SW-1:0];
      OP_SHR:  alu_res = a_q >> b_q[SW-1:0];
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_LTU:  alu_res = {{(BITS-1){1'b0}}, (a_q < b_q)};
      OP_EQ:   alu_res = {{(BITS-1){1'b0}}, (a_q == b_q)};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        op_d  = op_sel;
        a_d   = a_sel;
        b_d   = b_sel;
        id_d  = 3'(gnt_idx);
        ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      EXEC: begin
        rsp_data_d  = alu_res;
        rsp_err_d   = alu_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        ops_done_d  = ops_done_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Grant is suppressed while reset is asserted so no requester sees a phantom handshake.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = reset_n && (state_q == IDLE) && gnt_any && (gnt_idx == PW'(i));
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_expr_alu_rr_sched.sv
// Scoreboard bench for expr_alu_rr_sched: per-requester op queues feed the DUT,
// a transaction-level model predicts grants and results, a monitor compares.
`timescale 1ns/1ps
module tb_expr_alu_rr_sched;
  localparam int unsigned BITS = 32;
  localparam int unsigned NREQ = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [4*NREQ-1:0]    req_op;
  logic [BITS*NREQ-1:0] req_a, req_b;
  logic                 rsp_valid, rsp_ready;
  logic [BITS-1:0]      rsp_data;
  logic [2:0]           rsp_id;
  logic                 rsp_err;
  logic [15:0]          ops_done;

  expr_alu_rr_sched #(.BITS(BITS), .NREQ(NREQ)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .ops_done(ops_done)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [3:0] op; logic [BITS-1:0] a; logic [BITS-1:0] b; } req_t;
  typedef struct packed { logic [BITS-1:0] data; logic err; logic [2:0] id; } rsp_t;

  int   total = 0;
  int   bad   = 0;
  req_t rq [NREQ][$];
  int   gnt_seen [NREQ];
  int   rdy_mode = 0;
  int   pre_seq = 0;
  logic [15:0] pre_val = '0;

  rsp_t        exp_q[$];
  logic [2:0]  id_log[$];
  logic [BITS-1:0] data_log[$];
  logic        err_log[$];
  int          gcyc_log[$];
  int          m_ptr = 0;
  bit          m_busy = 1'b0;
  logic [15:0] m_cnt = '0;
  int          cyc = 0;
  int          g_cyc = 0;
  int          pre_seen = 0;
  bit          prev_v = 1'b0;
  rsp_t        held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t model(input req_t r, input int id);
    rsp_t o;
    int unsigned sh;
    sh = r.b % BITS;
    o.data = '0;
    o.err  = 1'b0;
    o.id   = 3'(id);
    case (r.op)
      4'd0: o.data = r.a + r.b;
      4'd1: o.data = r.a - r.b;
      4'd2: o.data = r.a << sh;
      4'd3: o.data = r.a >> sh;
      4'd4: o.data = r.a & r.b;
      4'd5: o.data = r.a | r.b;
      4'd6: o.data = r.a ^ r.b;
      4'd7: o.data = ~(r.a ^ r.b);
      4'd8: o.data = (r.a < r.b) ? 1 : 0;
      4'd9: o.data = (r.a == r.b) ? 1 : 0;
      default: o.err = 1'b1;
    endcase
    return o;
  endfunction

  // Feeder: retires granted ops, presents queue heads, drives rsp_ready.
  initial begin
    int consumed [NREQ];
    for (int i = 0; i < NREQ; i++) consumed[i] = 0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        while (consumed[i] < gnt_seen[i]) begin
          if (rq[i].size() > 0) void'(rq[i].pop_front());
          consumed[i]++;
        end
        req_valid[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          req_op[4*i +: 4]    = rq[i][0].op;
          req_a[BITS*i +: BITS] = rq[i][0].a;
          req_b[BITS*i +: BITS] = rq[i][0].b;
        end
      end
      rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor and transaction-level model.
  initial begin
    for (int i = 0; i < NREQ; i++) gnt_seen[i] = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete(); m_ptr = 0; m_busy = 1'b0; m_cnt = '0; prev_v = 1'b0;
      end else begin
        int win;
        logic [NREQ-1:0] exp_rdy;
        if (pre_seen != pre_seq) begin pre_seen = pre_seq; m_cnt = pre_val; end
        chk("ops_done", 64'(ops_done), 64'(m_cnt));
        win = -1;
        exp_rdy = '0;
        if (!m_busy)
          for (int k = 0; k < NREQ; k++)
            if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (win >= 0) begin
          exp_q.push_back(model(rq[win][0], win));
          m_ptr = (win + 1) % NREQ;
          m_busy = 1'b1;
          g_cyc = cyc;
          gcyc_log.push_back(cyc);
          gnt_seen[win]++;
        end
        if (m_busy && cyc - g_cyc >= 2) chk("rsp_valid_latency", 64'(rsp_valid), 64'd1);
        if (rsp_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp actual=%0h required=none t=%0t", rsp_data, $time);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
          end
          held = '{data: rsp_data, err: rsp_err, id: rsp_id};
          id_log.push_back(rsp_id); data_log.push_back(rsp_data); err_log.push_back(rsp_err);
        end else if (rsp_valid && prev_v) begin
          chk("hold_data", 64'(rsp_data), 64'(held.data));
          chk("hold_id_err", 64'({rsp_id, rsp_err}), 64'({held.id, held.err}));
        end
        if (rsp_valid && rsp_ready) begin m_cnt = m_cnt + 16'd1; m_busy = 1'b0; end
        prev_v = rsp_valid;
      end
      cyc++;
    end
  end

  function automatic bit quiet();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b0;
    return exp_q.size() == 0 && !m_busy && !rsp_valid;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    do begin @(posedge clock); #3; n++; end while (!quiet() && n < maxc);
    if (n >= maxc) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=busy required=idle t=%0t", nm, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset_n = 1'b0;
    @(posedge clock); #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id_err", 64'({rsp_id, rsp_err}), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [BITS-1:0] d,
                         input logic e, input logic [2:0] id);
    if (idx >= data_log.size()) begin
      total++; bad++;
      $display("FAIL %s_missing actual=%0d required>%0d", nm, data_log.size(), idx);
    end else begin
      chk({nm, "_data"}, 64'(data_log[idx]), 64'(d));
      chk({nm, "_err_id"}, 64'({err_log[idx], id_log[idx]}), 64'({e, id}));
    end
  endtask

  initial begin
    int base, gb;
    logic [BITS-1:0] sweep_exp [11];
    logic [2:0] rr_exp [8];
    sweep_exp = '{32'hF3, 32'hED, 32'h780, 32'h1E, 32'h0, 32'hF3, 32'hF3,
                  32'hFFFF_FF0C, 32'h0, 32'h0, 32'h0};
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd3, 3'd1};

    do_reset();

    // Basic ADD with wrap-around.
    base = data_log.size();
    rq[0].push_back('{op: 4'd0, a: 32'hFFFF_FFFF, b: 32'd2});
    wait_idle("add", 50);
    chk_log("add", base, 32'd1, 1'b0, 3'd0);
    chk("add_ops_done", 64'(ops_done), 64'd1);

    // Round-robin order and 3-cycle grant spacing.
    do_reset();
    base = data_log.size(); gb = gcyc_log.size();
    for (int i = 0; i < 2; i++) rq[0].push_back('{op: 4'd0, a: $urandom, b: $urandom});
    for (int i = 0; i < 3; i++) rq[1].push_back('{op: 4'd1, a: $urandom, b: $urandom});
    rq[2].push_back('{op: 4'd6, a: $urandom, b: $urandom});
    for (int i = 0; i < 2; i++) rq[3].push_back('{op: 4'd5, a: $urandom, b: $urandom});
    wait_idle("rr", 200);
    for (int k = 0; k < 8; k++) begin
      if (base + k < id_log.size()) chk("rr_order", 64'(id_log[base + k]), 64'(rr_exp[k]));
      else begin total++; bad++; $display("FAIL rr_order_missing actual=none required=%0d", rr_exp[k]); end
    end
    for (int k = 1; k < 8; k++)
      if (gb + k < gcyc_log.size())
        chk("rr_spacing", 64'(gcyc_log[gb + k] - gcyc_log[gb + k - 1]), 64'd3);

    // Operator sweep on requester 2, plus one illegal opcode.
    base = data_log.size();
    for (int op = 0; op < 10; op++) rq[2].push_back('{op: 4'(op), a: 32'hF0, b: 32'h3});
    rq[2].push_back('{op: 4'd12, a: 32'hF0, b: 32'h3});
    wait_idle("sweep", 200);
    for (int k = 0; k < 11; k++) chk_log("sweep", base + k, sweep_exp[k], (k == 10), 3'd2);

    // Backpressure: hold rsp_ready low for 5 cycles with requesters 1 and 2 pending.
    rdy_mode = 2;
    rq[1].push_back('{op: 4'd7, a: $urandom, b: $urandom});
    rq[2].push_back('{op: 4'd8, a: $urandom, b: $urandom});
    begin
      int n = 0;
      do begin @(posedge clock); #3; n++; end while (!rsp_valid && n < 20);
      if (n >= 20) begin total++; bad++; $display("FAIL bp_timeout actual=0 required=1"); end
    end
    repeat (5) @(posedge clock);
    rdy_mode = 0;
    wait_idle("bp", 100);

    // Reset while EXEC: in-flight op dropped, first grant after reset goes lowest valid.
    gb = gcyc_log.size();
    rq[0].push_back('{op: 4'd0, a: 32'd5, b: 32'd6});
    begin
      int n = 0;
      do begin @(posedge clock); #2; n++; end while (gcyc_log.size() == gb && n < 20);
      if (n >= 20) begin total++; bad++; $display("FAIL midrst_grant_timeout actual=0 required=1"); end
    end
    reset_n = 1'b0;
    rq[3].push_back('{op: 4'd4, a: 32'hFF00, b: 32'h0FF0});
    rq[1].push_back('{op: 4'd9, a: 32'd7, b: 32'd7});
    @(posedge clock); #2;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
    chk("midrst_ops_done", 64'(ops_done), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    base = data_log.size();
    wait_idle("midrst", 100);
    chk_log("midrst_first", base, 32'd1, 1'b0, 3'd1);
    chk_log("midrst_second", base + 1, 32'h0F00, 1'b0, 3'd3);

    // Counter wrap: preload near the top, then complete three ops.
    @(posedge clock); #2;
    dut.ops_done_q = 16'hFFFD;
    pre_val = 16'hFFFD; pre_seq++;
    for (int i = 0; i < 2; i++) rq[0].push_back('{op: 4'd2, a: $urandom, b: $urandom});
    wait_idle("wrap_a", 50);
    chk("wrap_ffff", 64'(ops_done), 64'hFFFF);
    rq[0].push_back('{op: 4'd3, a: $urandom, b: $urandom});
    wait_idle("wrap_b", 50);
    chk("wrap_zero", 64'(ops_done), 64'h0);

    // Randomized traffic with random backpressure.
    do_reset();
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      int r;
      req_t t;
      r = $urandom_range(0, NREQ - 1);
      t.op = 4'($urandom_range(0, 15));
      t.a = $urandom;
      t.b = ($urandom_range(0, 3) == 0) ? t.a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      rq[r].push_back(t);
      repeat ($urandom_range(0, 4)) @(posedge clock);
    end
    wait_idle("rand", 4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
